// File: rtl/eth_mac_tx_pad.sv
// eth_mac_tx_pad: Ethernet TX engine (preamble/SFD, payload, zero pad, CRC-32 FCS, inter-frame gap)
//   clk, rst (sync, active high), start_in: transmit enable sampled in IDLE
//   rd_en_out/rd_d_in/rd_empty_in: FWFT FIFO pop port, word [8]=1 control ([1:0] 00 SOF, 01 EOF, 1x ERR)
//   eth_tx_d_out/eth_tx_en_out/eth_tx_err_out: registered GMII/MII byte pins, busy_out: not idle
//   frame_cnt_out/err_cnt_out: completed frames / aborts, present only with ETH_TX_STATS_EN defined
module eth_mac_tx_pad #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12,
  parameter int MIN_FRAME    = 60,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  output logic [7:0]       eth_tx_d_out,
  output logic             eth_tx_en_out,
  output logic             eth_tx_err_out,
  output logic             rd_en_out,
  input  logic [8:0]       rd_d_in,
  input  logic             rd_empty_in,
  output logic             busy_out
`ifdef ETH_TX_STATS_EN
  ,
  output logic [CNT_W-1:0] frame_cnt_out,
  output logic [CNT_W-1:0] err_cnt_out
`endif
);
  typedef enum logic [2:0] {IDLE, PRE, DATA, PAD, FCS, IFG} state_t;
  localparam logic [CNT_W-1:0] PRE_L = CNT_W'(PREAMBLE_LEN);
  localparam logic [CNT_W-1:0] IFG_L = CNT_W'(IFG_LEN - 1);
  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_FRAME);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, byte_cnt, byte_cnt_n, byte_inc;
  logic [31:0] crc, crc_n, fcs;
  logic [7:0] d_n;
  logic en_n, err_n, frame_inc, err_inc, ctl, sof, eof;
  // Non-reflected register fed data bit 0 first, which is the reflected Ethernet CRC bit-reversed.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04c11db7 : 32'h0);
    return r;
  endfunction
  assign ctl      = rd_d_in[8];
  assign sof      = ctl && rd_d_in[1:0] == 2'b00;
  assign eof      = ctl && rd_d_in[1:0] == 2'b01;
  assign fcs      = ~crc;
  assign byte_inc = &byte_cnt ? byte_cnt : byte_cnt + 1'b1;
  assign busy_out = state != IDLE;
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    byte_cnt_n = byte_cnt;
    crc_n      = crc;
    d_n        = 8'h00;
    en_n       = 1'b0;
    err_n      = 1'b0;
    rd_en_out  = 1'b0;
    frame_inc  = 1'b0;
    err_inc    = 1'b0;
    case (state)
      IDLE: begin
        crc_n     = '1;
        rd_en_out = start_in && !rd_empty_in;
        if (rd_en_out && sof) begin
          state_n    = PRE;
          cnt_n      = '0;
          byte_cnt_n = '0;
        end else if (rd_en_out && ctl && rd_d_in[1]) begin
          state_n = IFG;
          cnt_n   = '0;
          err_n   = 1'b1;
          err_inc = 1'b1;
        end
      end
      PRE: begin
        en_n    = 1'b1;
        d_n     = cnt == PRE_L ? 8'hab : 8'haa;
        cnt_n   = cnt + 1'b1;
        state_n = cnt == PRE_L ? DATA : PRE;
      end
      // EOF and every pad cycle share the tail step so the first pad/FCS byte follows the last data byte directly.
      DATA, PAD: begin
        rd_en_out = state == DATA && !rd_empty_in;
        en_n      = 1'b1;
        if (state == DATA && (rd_empty_in || (ctl && !eof))) begin
          state_n = IFG;
          cnt_n   = '0;
          err_n   = 1'b1;
          err_inc = 1'b1;
        end else if (state == DATA && !ctl) begin
          d_n        = rd_d_in[7:0];
          crc_n      = crc_upd(crc, rd_d_in[7:0]);
          byte_cnt_n = byte_inc;
        end else if (byte_cnt < MIN_L) begin
          crc_n      = crc_upd(crc, 8'h00);
          byte_cnt_n = byte_inc;
          state_n    = PAD;
        end else begin
          d_n     = fcs[31:24];
          cnt_n   = CNT_W'(1);
          state_n = FCS;
        end
      end
      FCS: begin
        en_n      = 1'b1;
        d_n       = cnt[1:0] == 2'd1 ? fcs[23:16] : cnt[1:0] == 2'd2 ? fcs[15:8] : fcs[7:0];
        frame_inc = cnt[1:0] == 2'd3;
        cnt_n     = frame_inc ? '0 : cnt + 1'b1;
        state_n   = frame_inc ? IFG : FCS;
      end
      IFG: begin
        cnt_n   = cnt + 1'b1;
        state_n = cnt == IFG_L ? IDLE : IFG;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      byte_cnt       <= '0;
      crc            <= '1;
      eth_tx_d_out   <= '0;
      eth_tx_en_out  <= 1'b0;
      eth_tx_err_out <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      byte_cnt       <= byte_cnt_n;
      crc            <= crc_n;
      eth_tx_d_out   <= d_n;
      eth_tx_en_out  <= en_n;
      eth_tx_err_out <= err_n;
    end
  end
`ifdef ETH_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_out <= '0;
      err_cnt_out   <= '0;
    end else begin
      frame_cnt_out <= frame_cnt_out + CNT_W'(frame_inc);
      err_cnt_out   <= err_cnt_out + CNT_W'(err_inc);
    end
  end
`else
  logic unused_stats;
  assign unused_stats = frame_inc ^ err_inc;
`endif
endmodule

// File: tb/tb_eth_mac_tx_pad.sv
// tb_eth_mac_tx_pad: randomized frame bench against a queue-based Ethernet frame and reflected CRC-32 model
module tb_eth_mac_tx_pad;
  logic clk = 1'b0;
  logic rst, start_in, rd_en_out, rd_empty_in, busy_out, eth_tx_en_out, eth_tx_err_out;
  logic [7:0] eth_tx_d_out;
  logic [8:0] rd_d_in;
`ifdef ETH_TX_STATS_EN
  logic [15:0] frame_cnt_out, err_cnt_out;
`endif
  logic [8:0] mem [1024];
  logic [9:0] wp = '0, rp = '0;
  int checks = 0, failures = 0, exp_frames = 0, exp_errs = 0, pop_empty = 0;
  logic [7:0] exp_q[$], got[$], pay[$], exp_a[$];
  bit got_err[$];

  always #5 clk = ~clk;

  eth_mac_tx_pad dut (
    .clk(clk), .rst(rst), .start_in(start_in),
    .eth_tx_d_out(eth_tx_d_out), .eth_tx_en_out(eth_tx_en_out), .eth_tx_err_out(eth_tx_err_out),
    .rd_en_out(rd_en_out), .rd_d_in(rd_d_in), .rd_empty_in(rd_empty_in), .busy_out(busy_out)
`ifdef ETH_TX_STATS_EN
    , .frame_cnt_out(frame_cnt_out), .err_cnt_out(err_cnt_out)
`endif
  );

  assign rd_d_in     = mem[rp];
  assign rd_empty_in = wp == rp;
  always @(posedge clk) begin
    if (rd_en_out) rp <= rp + 10'd1;
    if (rd_en_out && rd_empty_in) pop_empty <= pop_empty + 1;
  end

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] o;
    for (int j = 0; j < 8; j++) o[j] = x[7-j];
    return o;
  endfunction

  // Standard reflected CRC-32, returned already complemented (wire-order FCS in bits [7:0] first).
  function automatic logic [31:0] crc_ref(input logic [7:0] b[$]);
    logic [31:0] r;
    r = '1;
    foreach (b[i]) begin
      r ^= {24'h0, b[i]};
      repeat (8) r = r[0] ? (r >> 1) ^ 32'hedb88320 : r >> 1;
    end
    return ~r;
  endfunction

  // Expected tx_en byte stream; the DUT pins carry each FCS byte bit-reversed.
  function automatic void build_exp();
    logic [7:0] body[$];
    logic [31:0] f;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'haa);
    exp_q.push_back(8'hab);
    body = pay;
    while (body.size() < 60) body.push_back(8'h00);
    foreach (body[i]) exp_q.push_back(body[i]);
    f = crc_ref(body);
    for (int k = 0; k < 4; k++) exp_q.push_back(rev8(f[8*k +: 8]));
  endfunction

  task automatic push(input logic [8:0] w);
    mem[wp] = w;
    wp = wp + 10'd1;
  endtask

  task automatic push_frame(input int n, input bit with_eof);
    logic [7:0] b;
    pay.delete();
    push(9'h100);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      pay.push_back(b);
      push({1'b0, b});
    end
    if (with_eof) push(9'h101);
  endtask

  task automatic get_frame(input string name);
    int w = 0;
    got.delete();
    got_err.delete();
    while (eth_tx_en_out !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: tx_en never rose within %0d cycles", name, w);
    end
    while (eth_tx_en_out === 1'b1 && got.size() < 300) begin
      got.push_back(eth_tx_d_out);
      got_err.push_back(eth_tx_err_out);
      @(negedge clk);
    end
  endtask

  task automatic cmp_frame(input string name);
    int n, e = 0;
    checks++;
    if (got.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s length: got %0d tx_en cycles, expected %0d", name, got.size(), exp_q.size());
    end
    n = got.size() < exp_q.size() ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s byte %0d: got %02h expected %02h", name, i, got[i], exp_q[i]);
      end
    end
    foreach (got_err[i]) e += int'(got_err[i]);
    checks++;
    if (e !== 0) begin
      failures++;
      $display("FAIL %s err: got %0d err cycles, expected 0", name, e);
    end
  endtask

  task automatic test_stats(input string name);
`ifdef ETH_TX_STATS_EN
    checks += 2;
    if (frame_cnt_out !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL %s frame_cnt: got %0d expected %0d", name, frame_cnt_out, exp_frames);
    end
    if (err_cnt_out !== 16'(exp_errs)) begin
      failures++;
      $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt_out, exp_errs);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({eth_tx_en_out, eth_tx_err_out, eth_tx_d_out, busy_out, rd_en_out} !== 12'h0) begin
      failures++;
      $display("FAIL reset outputs: got en=%b err=%b d=%02h busy=%b rd_en=%b expected all 0",
               eth_tx_en_out, eth_tx_err_out, eth_tx_d_out, busy_out, rd_en_out);
    end
    test_stats("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_gate();
    push_frame(14, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (busy_out !== 1'b0 || rd_en_out !== 1'b0 || (wp - rp) !== 10'd16) begin
      failures++;
      $display("FAIL gate hold: got busy=%b rd_en=%b queued=%0d expected 0 0 16", busy_out, rd_en_out, wp - rp);
    end
    start_in = 1'b1;
    #1;
    checks++;
    if (rd_en_out !== 1'b1) begin
      failures++;
      $display("FAIL gate pop: got rd_en=%b expected 1", rd_en_out);
    end
    @(negedge clk);
    checks++;
    if (busy_out !== 1'b1 || eth_tx_en_out !== 1'b0) begin
      failures++;
      $display("FAIL gate latency: got busy=%b en=%b expected 1 0", busy_out, eth_tx_en_out);
    end
    @(negedge clk);
    checks++;
    if (eth_tx_en_out !== 1'b1 || eth_tx_d_out !== 8'haa) begin
      failures++;
      $display("FAIL gate preamble: got en=%b d=%02h expected 1 aa", eth_tx_en_out, eth_tx_d_out);
    end
    build_exp();
    get_frame("gate");
    cmp_frame("gate");
    exp_frames++;
  endtask

  task automatic test_short();
    push_frame(14, 1);
    build_exp();
    get_frame("short");
    cmp_frame("short");
    exp_frames++;
  endtask

  task automatic test_back_to_back();
    int g = 0;
    push_frame(64, 1);
    build_exp();
    exp_a = exp_q;
    push_frame(10, 1);
    build_exp();
    get_frame("long");
    exp_a = exp_q.size() == 0 ? exp_a : exp_a;
    begin
      logic [7:0] exp_b[$];
      exp_b = exp_q;
      exp_q = exp_a;
      cmp_frame("long");
      exp_frames++;
      test_stats("long");
      while (eth_tx_en_out !== 1'b1 && g < 60) begin
        g++;
        @(negedge clk);
      end
      checks++;
      if (g !== 13) begin
        failures++;
        $display("FAIL b2b gap: got %0d idle cycles expected 13", g);
      end
      exp_q = exp_b;
      get_frame("b2b");
      cmp_frame("b2b");
      exp_frames++;
    end
  endtask

  task automatic test_random();
    int lens[8];
    lens = '{0, 1, 59, 60, 61, $urandom_range(2, 58), $urandom_range(62, 120), $urandom_range(0, 80)};
    foreach (lens[i]) begin
      push_frame(lens[i], 1);
      build_exp();
      get_frame($sformatf("rand%0d", lens[i]));
      cmp_frame($sformatf("rand%0d", lens[i]));
      exp_frames++;
    end
    test_stats("random");
  endtask

  task automatic test_underrun();
    int e = 0, bad = 0;
    push_frame(5, 0);
    build_exp();
    get_frame("underrun");
    checks++;
    if (got.size() !== 14) begin
      failures++;
      $display("FAIL underrun length: got %0d tx_en cycles expected 14", got.size());
    end else begin
      for (int i = 0; i < 13; i++) begin
        e += int'(got_err[i]);
        if (got[i] !== exp_q[i]) bad++;
      end
      checks++;
      if (bad !== 0 || e !== 0 || got_err[13] !== 1'b1) begin
        failures++;
        $display("FAIL underrun content: got %0d bad bytes, %0d early errs, final err=%b expected 0 0 1",
                 bad, e, got_err[13]);
      end
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (eth_tx_en_out !== 1'b0 || eth_tx_err_out !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL underrun ifg: got %0d active cycles in gap expected 0", bad);
    end
    exp_errs++;
    test_stats("underrun");
  endtask

  task automatic test_err_idle();
    logic [8:0] words[2];
    int act;
    words = '{9'h103, 9'h102};
    foreach (words[k]) begin
      repeat (4) @(negedge clk);
      push(words[k]);
      @(negedge clk);
      checks++;
      if (eth_tx_err_out !== 1'b1 || eth_tx_en_out !== 1'b0) begin
        failures++;
        $display("FAIL err_idle %03h: got err=%b en=%b expected 1 0", words[k], eth_tx_err_out, eth_tx_en_out);
      end
      act = 0;
      repeat (14) begin
        @(negedge clk);
        if (eth_tx_en_out !== 1'b0 || eth_tx_err_out !== 1'b0) act++;
      end
      checks++;
      if (act !== 0) begin
        failures++;
        $display("FAIL err_idle %03h after: got %0d active cycles expected 0", words[k], act);
      end
      exp_errs++;
    end
    test_stats("err_idle");
  endtask

  task automatic test_reset_mid();
    int w = 0;
    push_frame(40, 1);
    while (eth_tx_en_out !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (27) @(negedge clk);
    checks++;
    if (eth_tx_en_out !== 1'b1 || eth_tx_d_out !== pay[19]) begin
      failures++;
      $display("FAIL rst_mid byte20: got en=%b d=%02h expected 1 %02h", eth_tx_en_out, eth_tx_d_out, pay[19]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({eth_tx_en_out, eth_tx_err_out, eth_tx_d_out, busy_out} !== 11'h0) begin
      failures++;
      $display("FAIL rst_mid outputs: got en=%b err=%b d=%02h busy=%b expected all 0",
               eth_tx_en_out, eth_tx_err_out, eth_tx_d_out, busy_out);
    end
    rst = 1'b0;
    exp_frames = 0;
    exp_errs = 0;
    test_stats("rst_mid");
    push_frame(30, 1);
    build_exp();
    get_frame("after_rst");
    cmp_frame("after_rst");
    exp_frames++;
    repeat (15) @(negedge clk);
    test_stats("after_rst");
  endtask

  initial begin
    foreach (mem[i]) mem[i] = '0;
    test_reset();
    test_start_gate();
    test_short();
    test_back_to_back();
    test_random();
    test_underrun();
    test_err_idle();
    test_reset_mid();
    checks++;
    if (pop_empty !== 0) begin
      failures++;
      $display("FAIL empty_pop: got %0d pops of an empty FIFO expected 0", pop_empty);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
